equilibrium_rodada_ctrl: RTL and testbench

Round sequencer for the balance game, placed beside the game-flow control unit. It times the preparation window and raises `prep_done`. It then referees each play round: either the ball holds in the target zone, or the round times out. It pulses `ponto_evento` and keeps score, level and lives. Its round time limit shrinks as the level rises.

---
 rtl/equilibrium_pkg.sv | 23 ++
 rtl/equilibrium_ms_counter.sv | 38 +++
 rtl/equilibrium_rodada_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_equilibrium_rodada_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/equilibrium_pkg.sv
// Shared definitions for the balance-game round sequencer: state encoding and
// default timing constants (all timings in ms ticks).
package equilibrium_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_ARMED = 3'd2,
        ST_PLAY  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_SCORE = 3'd5
    } state_e;

    localparam int PREP_MS_DEF       = 2000;
    localparam int HOLD_MS_DEF       = 500;
    localparam int PLAY_MS_BASE_DEF  = 10000;
    localparam int PLAY_MS_STEP_DEF  = 1000;
    localparam int PLAY_MS_MIN_DEF   = 3000;
    localparam int ACERTOS_NIVEL_DEF = 3;
    localparam int NIVEL_MAX_DEF     = 7;
    localparam int VIDAS_INI_DEF     = 3;

endpackage

// File: rtl/equilibrium_ms_counter.sv
// Tick-enabled saturating up-counter with synchronous clear. tc_o flags that the
// count has reached limit_i, including on the tick that gets it there.
module equilibrium_ms_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         tick_i,
    input  logic [W-1:0] limit_i,
    output logic         tc_o
);

    logic [W-1:0] count_q, count_d;
    logic [W:0]   count_inc;

    assign count_inc = {1'b0, count_q} + {{W{1'b0}}, 1'b1};

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i && !(&count_q)) begin
            count_d = count_inc[W-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q >= limit_i) || (tick_i && (count_inc >= {1'b0, limit_i}));

endmodule

// File: rtl/equilibrium_rodada_ctrl.sv
// Round sequencer for the balance game: times the preparation window, referees
// each play round (hold-in-target vs timeout) and keeps score, level and lives.
//
//   state | meaning
//   IDLE  | waiting for start_prep (blocked while game_over)
//   PREP  | timing the preparation window
//   ARMED | prep done, waiting for jogando
//   PLAY  | round running, ball outside target
//   HOLD  | round running, ball held in target
//   SCORE | one-cycle result strobe
module equilibrium_rodada_ctrl
    import equilibrium_pkg::*;
#(
    parameter int PREP_MS       = PREP_MS_DEF,
    parameter int HOLD_MS       = HOLD_MS_DEF,
    parameter int PLAY_MS_BASE  = PLAY_MS_BASE_DEF,
    parameter int PLAY_MS_STEP  = PLAY_MS_STEP_DEF,
    parameter int PLAY_MS_MIN   = PLAY_MS_MIN_DEF,
    parameter int ACERTOS_NIVEL = ACERTOS_NIVEL_DEF,
    parameter int NIVEL_MAX     = NIVEL_MAX_DEF,
    parameter int VIDAS_INI     = VIDAS_INI_DEF,
    parameter int CNT_W         = 16,
    parameter int PTS_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick_ms,
    input  logic             clear_jogo,
    input  logic             start_prep,
    input  logic             jogando,
    input  logic             alvo_ok,
    output logic             prep_done,
    output logic             ponto_evento,
    output logic             acerto,
    output logic [PTS_W-1:0] pontos,
    output logic [2:0]       nivel,
    output logic [2:0]       vidas,
    output logic             game_over,
    output logic [2:0]       db_estado
);

    localparam int HIT_W = (ACERTOS_NIVEL > 1) ? $clog2(ACERTOS_NIVEL) : 1;
    localparam int LW    = CNT_W + 3;

    localparam logic [CNT_W-1:0] PREP_LIM   = CNT_W'(PREP_MS);
    localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_MS);
    localparam logic [HIT_W-1:0] HIT_LAST   = HIT_W'(ACERTOS_NIVEL - 1);
    localparam logic [2:0]       NIVEL_TOP  = 3'(NIVEL_MAX);
    localparam logic [2:0]       VIDAS_LOAD = 3'(VIDAS_INI);

    state_e             state_q, state_d;
    logic               prep_done_q, prep_done_d;
    logic               acerto_q, acerto_d;
    logic [PTS_W-1:0]   pontos_q, pontos_d;
    logic [2:0]         nivel_q, nivel_d;
    logic [2:0]         vidas_q, vidas_d;
    logic               game_over_q, game_over_d;
    logic [HIT_W-1:0]   hits_q, hits_d;
    logic [CNT_W-1:0]   play_lim_q, play_lim_d;

    logic               timer_clr, timer_tc, hold_clr, hold_tc;
    logic [CNT_W-1:0]   timer_lim;
    logic               prep_fim, score_hit, score_miss;
    logic [LW-1:0]      lim_base, lim_red, lim_diff, lim_full;
    logic [CNT_W-1:0]   lim_sat;

    // Round limit for the current level, floored at PLAY_MS_MIN without underflow.
    assign lim_base = LW'(PLAY_MS_BASE);
    assign lim_red  = LW'(nivel_q) * LW'(PLAY_MS_STEP);
    assign lim_diff = (lim_red >= lim_base) ? '0 : (lim_base - lim_red);
    assign lim_full = (lim_diff > LW'(PLAY_MS_MIN)) ? lim_diff : LW'(PLAY_MS_MIN);
    assign lim_sat  = (|lim_full[LW-1:CNT_W]) ? '1 : lim_full[CNT_W-1:0];

    assign timer_lim = (state_q == ST_PREP) ? PREP_LIM : play_lim_q;

    always_comb begin
        state_d    = state_q;
        prep_fim   = 1'b0;
        score_hit  = 1'b0;
        score_miss = 1'b0;
        if (clear_jogo) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_prep && !game_over_q) state_d = ST_PREP;
                end
                ST_PREP: begin
                    if (!start_prep) begin
                        state_d = ST_IDLE;
                    end else if (timer_tc) begin
                        state_d  = ST_ARMED;
                        prep_fim = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (jogando) state_d = ST_PLAY;
                end
                // Expiry outranks a fresh target entry: the ball was never held.
                ST_PLAY: begin
                    if (!jogando) begin
                        state_d = ST_IDLE;
                    end else if (timer_tc) begin
                        state_d    = ST_SCORE;
                        score_miss = 1'b1;
                    end else if (alvo_ok) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!jogando) begin
                        state_d = ST_IDLE;
                    end else if (alvo_ok && hold_tc) begin
                        state_d   = ST_SCORE;
                        score_hit = 1'b1;
                    end else if (timer_tc) begin
                        state_d    = ST_SCORE;
                        score_miss = 1'b1;
                    end else if (!alvo_ok) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_SCORE: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // The play timer survives PLAY<->HOLD moves; every other state entry restarts it.
    assign timer_clr = (state_d != state_q) &&
                       !(((state_q == ST_PLAY) && (state_d == ST_HOLD)) ||
                         ((state_q == ST_HOLD) && (state_d == ST_PLAY)));
    assign hold_clr  = (state_q != ST_HOLD);

    equilibrium_ms_counter #(.W(CNT_W)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear_i (timer_clr),
        .tick_i  (tick_ms),
        .limit_i (timer_lim),
        .tc_o    (timer_tc)
    );

    equilibrium_ms_counter #(.W(CNT_W)) u_hold (
        .clock   (clock),
        .reset   (reset),
        .clear_i (hold_clr),
        .tick_i  (tick_ms),
        .limit_i (HOLD_LIM),
        .tc_o    (hold_tc)
    );

    always_comb begin
        prep_done_d = prep_fim;
        acerto_d    = acerto_q;
        pontos_d    = pontos_q;
        nivel_d     = nivel_q;
        vidas_d     = vidas_q;
        game_over_d = game_over_q;
        hits_d      = hits_q;
        play_lim_d  = play_lim_q;
        if ((state_q == ST_ARMED) && (state_d == ST_PLAY)) begin
            play_lim_d = lim_sat;
        end
        if (clear_jogo) begin
            pontos_d    = '0;
            nivel_d     = '0;
            hits_d      = '0;
            vidas_d     = VIDAS_LOAD;
            game_over_d = 1'b0;
        end else if (score_hit) begin
            acerto_d = 1'b1;
            if (!(&pontos_q)) pontos_d = pontos_q + 1'b1;
            if (hits_q == HIT_LAST) begin
                hits_d = '0;
                if (nivel_q < NIVEL_TOP) nivel_d = nivel_q + 3'd1;
            end else begin
                hits_d = hits_q + 1'b1;
            end
        end else if (score_miss) begin
            acerto_d = 1'b0;
            if (vidas_q != 3'd0) vidas_d = vidas_q - 3'd1;
            if (vidas_q <= 3'd1) game_over_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prep_done_q <= 1'b0;
            acerto_q    <= 1'b0;
            pontos_q    <= '0;
            nivel_q     <= '0;
            vidas_q     <= VIDAS_LOAD;
            game_over_q <= 1'b0;
            hits_q      <= '0;
            play_lim_q  <= '0;
        end else begin
            state_q     <= state_d;
            prep_done_q <= prep_done_d;
            acerto_q    <= acerto_d;
            pontos_q    <= pontos_d;
            nivel_q     <= nivel_d;
            vidas_q     <= vidas_d;
            game_over_q <= game_over_d;
            hits_q      <= hits_d;
            play_lim_q  <= play_lim_d;
        end
    end

    assign prep_done    = prep_done_q;
    assign ponto_evento = (state_q == ST_SCORE);
    assign acerto       = acerto_q;
    assign pontos       = pontos_q;
    assign nivel        = nivel_q;
    assign vidas        = vidas_q;
    assign game_over    = game_over_q;
    assign db_estado    = state_q;

endmodule

// File: tb/tb_equilibrium_rodada_ctrl.sv
// Scoreboard bench for the round sequencer: a tick-level game model predicts each
// prep_done / ponto_evento strobe (cycle and register values); a monitor checks them.
module tb_equilibrium_rodada_ctrl;

    localparam int PREP = 4, HOLD = 3, BASE = 20, STEP = 5, MINL = 8;
    localparam int VIDAS = 2, ACN = 2, NMAX = 7, PTS_W = 8;
    localparam int P_IDLE = 0, P_PREP = 1, P_ARMED = 2, P_ROUND = 3, P_SCORED = 4;

    logic             clock = 1'b0;
    logic             reset, tick_ms, clear_jogo, start_prep, jogando, alvo_ok;
    logic             prep_done, ponto_evento, acerto, game_over;
    logic [PTS_W-1:0] pontos;
    logic [2:0]       nivel, vidas, db_estado;

    equilibrium_rodada_ctrl #(
        .PREP_MS(PREP), .HOLD_MS(HOLD), .PLAY_MS_BASE(BASE), .PLAY_MS_STEP(STEP),
        .PLAY_MS_MIN(MINL), .ACERTOS_NIVEL(ACN), .NIVEL_MAX(NMAX), .VIDAS_INI(VIDAS),
        .CNT_W(16), .PTS_W(PTS_W)
    ) dut (
        .clock(clock), .reset(reset), .tick_ms(tick_ms), .clear_jogo(clear_jogo),
        .start_prep(start_prep), .jogando(jogando), .alvo_ok(alvo_ok),
        .prep_done(prep_done), .ponto_evento(ponto_evento), .acerto(acerto),
        .pontos(pontos), .nivel(nivel), .vidas(vidas), .game_over(game_over),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic        kind;   // 0 = prep_done, 1 = ponto_evento
        logic [31:0] cyc;
        logic        acerto;
        logic [7:0]  pontos;
        logic [2:0]  nivel;
        logic [2:0]  vidas;
        logic        go;
        logic [2:0]  st;
    } ev_t;

    ev_t exp_q[$];
    ev_t got_e, exp_e;
    int  n_tests = 0, n_fail = 0;

    // Game model: phase plus tick counts since round start and since hold start.
    int m_phase, m_el, m_held, m_lim, m_pts, m_niv, m_vid, m_hits;
    bit m_holding, m_go, m_ac;

    task automatic model_reset();
        m_phase = P_IDLE; m_el = 0; m_held = 0; m_holding = 0; m_lim = 0;
        m_pts = 0; m_niv = 0; m_vid = VIDAS; m_hits = 0; m_go = 0; m_ac = 0;
    endtask

    task automatic push_ev(input bit kind);
        ev_t e;
        e.kind = kind; e.cyc = 32'(cyc + 1); e.acerto = m_ac; e.pontos = 8'(m_pts);
        e.nivel = 3'(m_niv); e.vidas = 3'(m_vid); e.go = m_go; e.st = kind ? 3'd5 : 3'd2;
        exp_q.push_back(e);
    endtask

    task automatic score(input bit hit);
        if (hit) begin
            m_ac = 1;
            if (m_pts < 255) m_pts++;
            m_hits++;
            if (m_hits == ACN) begin
                m_hits = 0;
                if (m_niv < NMAX) m_niv++;
            end
        end else begin
            m_ac = 0;
            if (m_vid > 0) m_vid--;
            if (m_vid == 0) m_go = 1;
        end
        m_phase = P_SCORED;
        push_ev(1);
    endtask

    task automatic model_edge(input bit tk, input bit clr, input bit sp, input bit jg, input bit al);
        int e, h;
        if (clr) begin
            m_pts = 0; m_niv = 0; m_hits = 0; m_vid = VIDAS; m_go = 0; m_phase = P_IDLE;
            return;
        end
        case (m_phase)
            P_IDLE: if (sp && !m_go) begin m_phase = P_PREP; m_el = 0; end
            P_PREP: begin
                if (!sp) m_phase = P_IDLE;
                else begin
                    e = m_el + int'(tk);
                    if (e >= PREP) begin m_phase = P_ARMED; push_ev(0); end
                    else m_el = e;
                end
            end
            P_ARMED: if (jg) begin
                m_phase = P_ROUND; m_el = 0; m_holding = 0;
                m_lim = BASE - m_niv * STEP;
                if (m_lim < MINL) m_lim = MINL;
            end
            P_ROUND: begin
                if (!jg) m_phase = P_IDLE;
                else begin
                    e = m_el + int'(tk);
                    if (m_holding) begin
                        h = m_held + int'(tk);
                        if (al && h >= HOLD) score(1);
                        else if (e >= m_lim) score(0);
                        else begin
                            m_el = e; m_held = h;
                            if (!al) m_holding = 0;
                        end
                    end else begin
                        if (e >= m_lim) score(0);
                        else begin
                            m_el = e;
                            if (al) begin m_holding = 1; m_held = 0; end
                        end
                    end
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    // Called at posedge+2; returns at the following posedge+2.
    task automatic drive(input bit tk, input bit clr, input bit sp, input bit jg, input bit al);
        tick_ms = tk; clear_jogo = clr; start_prep = sp; jogando = jg; alvo_ok = al;
        model_edge(tk, clr, sp, jg, al);
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_prep_done"}, 32'(prep_done), 0);
        chk({tag, "_ponto_evento"}, 32'(ponto_evento), 0);
        chk({tag, "_acerto"}, 32'(acerto), 0);
        chk({tag, "_pontos"}, 32'(pontos), 0);
        chk({tag, "_nivel"}, 32'(nivel), 0);
        chk({tag, "_vidas"}, 32'(vidas), VIDAS);
        chk({tag, "_game_over"}, 32'(game_over), 0);
        chk({tag, "_estado"}, 32'(db_estado), 0);
    endtask

    task automatic do_prep();
        for (int i = 0; i < 40 && m_phase != P_ARMED; i++) drive((i % 4) == 3, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic hit_round(input int epts, input int eniv);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        repeat (HOLD) drive(1, 0, 0, 1, 1);
        chk("hit_acerto", 32'(acerto), 1);
        chk("hit_pontos", 32'(pontos), 32'(epts));
        chk("hit_nivel", 32'(nivel), 32'(eniv));
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic miss_count(input string nm, input int pre_ticks, input int ereq);
        int n;
        n = pre_ticks;
        for (int k = 0; k < 40 && !ponto_evento; k++) begin
            drive(1, 0, 0, 1, 0);
            n++;
        end
        chk(nm, 32'(n), 32'(ereq));
        chk({nm, "_acerto"}, 32'(acerto), 0);
    endtask

    always @(negedge clock) begin
        if (!reset && (prep_done || ponto_evento)) begin
            got_e.kind = ponto_evento; got_e.cyc = 32'(cyc); got_e.acerto = acerto;
            got_e.pontos = pontos; got_e.nivel = nivel; got_e.vidas = vidas;
            got_e.go = game_over; got_e.st = db_estado;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d prep_done=%0b ponto_evento=%0b required=no strobe",
                         cyc, prep_done, ponto_evento);
            end else begin
                exp_e = exp_q.pop_front();
                if (got_e !== exp_e) begin
                    n_fail++;
                    $display("FAIL event got kind=%0d cyc=%0d ac=%0b pts=%0d niv=%0d vid=%0d go=%0b st=%0d required kind=%0d cyc=%0d ac=%0b pts=%0d niv=%0d vid=%0d go=%0b st=%0d",
                             got_e.kind, got_e.cyc, got_e.acerto, got_e.pontos, got_e.nivel, got_e.vidas, got_e.go, got_e.st,
                             exp_e.kind, exp_e.cyc, exp_e.acerto, exp_e.pontos, exp_e.nivel, exp_e.vidas, exp_e.go, exp_e.st);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit al_r;
        int g;
        reset = 1'b1;
        tick_ms = 0; clear_jogo = 0; start_prep = 0; jogando = 0; alvo_ok = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #2;
        check_reset_vals("reset");
        reset = 1'b0;
        @(posedge clock);
        #2;

        // Prep window: a tick every 4th cycle, strobe after the 4th tick.
        for (int i = 0; i < 40 && m_phase != P_ARMED; i++) drive((i % 4) == 3, 0, 1, 0, 0);
        chk("prep_pulse", 32'(prep_done), 1);
        chk("prep_state", 32'(db_estado), 2);
        drive(0, 0, 0, 0, 0);
        chk("prep_single", 32'(prep_done), 0);

        hit_round(1, 0);
        do_prep();
        hit_round(2, 1);

        // Broken hold: 2 ticks held, 1 tick out, 3 ticks held.
        do_prep();
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        repeat (2) drive(1, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        repeat (HOLD) drive(1, 0, 0, 1, 1);
        chk("broken_hold_evento", 32'(ponto_evento), 1);
        chk("broken_hold_pontos", 32'(pontos), 3);
        drive(0, 0, 0, 0, 0);

        // Level 1 limit is 15 ticks; an early broken hold must not restart the timer.
        do_prep();
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        repeat (2) drive(1, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 0);
        miss_count("timeout_l15", 2, 15);
        chk("miss1_vidas", 32'(vidas), 1);
        chk("miss1_game_over", 32'(game_over), 0);
        drive(0, 0, 0, 0, 0);

        do_prep(); hit_round(4, 2);
        do_prep(); hit_round(5, 2);
        do_prep(); hit_round(6, 3);

        // Level 3 limit floors at 8 ticks; this second miss ends the game.
        do_prep();
        drive(0, 0, 0, 1, 0);
        miss_count("timeout_l8", 0, 8);
        chk("miss2_vidas", 32'(vidas), 0);
        chk("miss2_game_over", 32'(game_over), 1);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) drive(i % 2, 0, 1, 0, 0);
        chk("game_over_blocks_prep", 32'(db_estado), 0);
        drive(0, 1, 0, 0, 0);
        chk("clear_vidas", 32'(vidas), VIDAS);
        chk("clear_pontos", 32'(pontos), 0);
        chk("clear_nivel", 32'(nivel), 0);
        chk("clear_game_over", 32'(game_over), 0);

        // Hold completes on the very tick the 20-tick limit expires.
        do_prep();
        drive(0, 0, 0, 1, 0);
        repeat (BASE - HOLD) drive(1, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        repeat (HOLD) drive(1, 0, 0, 1, 1);
        chk("tie_evento", 32'(ponto_evento), 1);
        chk("tie_acerto", 32'(acerto), 1);
        drive(0, 0, 0, 0, 0);

        // jogando drops mid-hold: abort with no strobe.
        do_prep();
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        drive(1, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1);
        chk("abort_estado", 32'(db_estado), 0);
        chk("abort_evento", 32'(ponto_evento), 0);
        chk("abort_pontos", 32'(pontos), 1);
        drive(0, 0, 0, 0, 0);

        // Randomized games against the model.
        repeat (30) begin
            if (m_go) begin
                repeat (5) drive($urandom_range(0, 1) == 1, 0, 1, 0, 0);
                drive(0, 1, 0, 0, 0);
            end
            g = 0;
            while (m_phase != P_ARMED && g < 200) begin
                drive($urandom_range(0, 2) == 0, 0, $urandom_range(0, 29) != 0, 0, 0);
                g++;
            end
            repeat ($urandom_range(0, 3)) drive($urandom_range(0, 1) == 1, 0, 0, 0, 0);
            al_r = 0; g = 0;
            while ((m_phase == P_ARMED || m_phase == P_ROUND) && g < 400) begin
                if ($urandom_range(0, 4) == 0) al_r = !al_r;
                drive($urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0, 0,
                      $urandom_range(0, 99) != 0, al_r);
                g++;
            end
            repeat ($urandom_range(1, 2)) drive(0, 0, 0, 0, 0);
        end

        // Asynchronous reset in the middle of a round.
        drive(0, 1, 0, 0, 0);
        do_prep();
        drive(0, 0, 0, 1, 0);
        repeat (3) drive(1, 0, 0, 1, 0);
        #1 reset = 1'b1;
        #1 check_reset_vals("midplay_reset");
        tick_ms = 0; clear_jogo = 0; start_prep = 0; jogando = 0; alvo_ok = 0;
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #2;
        check_reset_vals("after_reset");

        repeat (5) drive(0, 0, 0, 0, 0);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
